dot_acc_s8: RTL and testbench

- Streaming signed dot-product accumulator directly downstream of the 4x4 signed multiplier array.
- Consumes 8-bit two's-complement products one per cycle over a valid/ready handshake and sums LEN of them, or fewer if in_last ends the group early.
- Saturates the running sum to ACC_W bits and presents each group result on a valid/ready output port with a sticky overflow flag.

---
 rtl/dot_acc_s8.sv | 130 +++++++++++++
 tb/tb_dot_acc_s8.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot_acc_s8.sv
// Streaming signed dot-product accumulator for 8-bit products.
// Saturating group sums are returned on a valid/ready port with a sticky overflow flag.
module dot_acc_s8 #(
    parameter  int LEN   = 4,
    parameter  int ACC_W = 12,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [7:0]       in_prod,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_ovf
);

    typedef enum logic {
        S_ACC,
        S_HOLD
    } state_t;

    localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(LEN - 1);

    state_t                    state;
    state_t                    state_n;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_n;
    logic        [CNT_W-1:0]   cnt;
    logic        [CNT_W-1:0]   cnt_n;
    logic                      sticky;
    logic                      sticky_n;
    logic                      valid_n;
    logic signed [ACC_W-1:0]   sum_n;
    logic                      ovf_n;

    logic                      accept;
    logic                      xfer;
    logic                      final_beat;
    logic signed [ACC_W:0]     term;
    logic signed [ACC_W:0]     raw;
    logic                      clamp_hi;
    logic                      clamp_lo;
    logic                      clamp;
    logic signed [ACC_W-1:0]   sat;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign xfer       = out_valid && out_ready;
    assign final_beat = in_last || (cnt == CNT_END);

    // acc is always zero at the start of a group, so it doubles as the base
    assign term     = {{(ACC_W + 1 - 8){in_prod[7]}}, in_prod};
    assign raw      = {acc[ACC_W-1], acc} + term;
    assign clamp_hi = !raw[ACC_W] && raw[ACC_W-1];
    assign clamp_lo = raw[ACC_W] && !raw[ACC_W-1];
    assign clamp    = clamp_hi || clamp_lo;

    always_comb begin
        sat = raw[ACC_W-1:0];
        if (clamp_hi) begin
            sat = SUM_MAX;
        end else if (clamp_lo) begin
            sat = SUM_MIN;
        end
    end

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        sticky_n = sticky;
        valid_n  = out_valid;
        sum_n    = out_sum;
        ovf_n    = out_ovf;
        unique case (state)
            S_ACC: begin
                if (accept && final_beat) begin
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (xfer) begin
                    valid_n = 1'b0;
                    state_n = (accept && final_beat) ? S_HOLD : S_ACC;
                end
            end
            default: state_n = S_ACC;
        endcase
        if (accept) begin
            if (final_beat) begin
                sum_n    = sat;
                ovf_n    = sticky || clamp;
                valid_n  = 1'b1;
                acc_n    = '0;
                cnt_n    = '0;
                sticky_n = 1'b0;
            end else begin
                acc_n    = sat;
                cnt_n    = cnt + CNT_W'(1);
                sticky_n = sticky || clamp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            sticky    <= sticky_n;
            out_valid <= valid_n;
            out_sum   <= sum_n;
            out_ovf   <= ovf_n;
        end
    end

endmodule

// File: tb/tb_dot_acc_s8.sv
// Bench for dot_acc_s8: a 12-bit and an 8-bit accumulator share one input
// stream and are checked against a group-level saturating-sum model.
module tb_dot_acc_s8;

    localparam int LEN = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic        [7:0] in_prod;
    logic              in_last;
    logic              out_ready;

    logic              ready_a;
    logic              valid_a;
    logic signed [11:0] sum_a;
    logic              ovf_a;
    logic              ready_b;
    logic              valid_b;
    logic signed [7:0] sum_b;
    logic              ovf_b;

    int vectors;
    int miscompares;

    int     grp[$];
    bit     ev;
    longint es_a;
    longint es_b;
    bit     eo_a;
    bit     eo_b;

    dot_acc_s8 #(.LEN(LEN), .ACC_W(12)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ready_a),
        .in_prod(in_prod), .in_last(in_last),
        .out_valid(valid_a), .out_ready(out_ready),
        .out_sum(sum_a), .out_ovf(ovf_a)
    );

    dot_acc_s8 #(.LEN(LEN), .ACC_W(8)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ready_b),
        .in_prod(in_prod), .in_last(in_last),
        .out_valid(valid_b), .out_ready(out_ready),
        .out_sum(sum_b), .out_ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Saturate after every term, as a w-bit signed accumulator would.
    task automatic group_sum(input int w, output longint s, output bit o);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        s = 0;
        o = 1'b0;
        foreach (grp[i]) begin
            s = s + grp[i];
            if (s > mx) begin s = mx; o = 1'b1; end
            if (s < mn) begin s = mn; o = 1'b1; end
        end
    endtask

    task automatic model_step(input bit v, input int p, input bit l, input bit r);
        bit rdy;
        logic signed [7:0] pb;
        rdy = !ev || r;
        if (ev && r) ev = 1'b0;
        if (v && rdy) begin
            pb = p[7:0];
            grp.push_back(int'(pb));
            if (l || grp.size() == LEN) begin
                group_sum(12, es_a, eo_a);
                group_sum(8, es_b, eo_b);
                ev = 1'b1;
                grp.delete();
            end
        end
    endtask

    task automatic check_out();
        chk("valid_a", valid_a, ev);
        chk("valid_b", valid_b, ev);
        if (ev) begin
            chk("sum_a", sum_a, es_a);
            chk("ovf_a", ovf_a, eo_a);
            chk("sum_b", sum_b, es_b);
            chk("ovf_b", ovf_b, eo_b);
        end
    endtask

    // Called just after a falling edge; returns on the next falling edge.
    task automatic cycle(input bit v, input int p, input bit l, input bit r);
        in_valid  = v;
        in_prod   = p[7:0];
        in_last   = l;
        out_ready = r;
        #1;
        chk("ready_a", ready_a, (!ev || r));
        chk("ready_b", ready_b, (!ev || r));
        @(posedge clk);
        model_step(v, p, l, r);
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid_a", valid_a, 0);
        chk("rst_valid_b", valid_b, 0);
        chk("rst_sum_a", sum_a, 0);
        chk("rst_sum_b", sum_b, 0);
        chk("rst_ovf_a", ovf_a, 0);
        ev = 1'b0;
        es_a = 0;
        es_b = 0;
        eo_a = 1'b0;
        eo_b = 1'b0;
        grp.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p;
        vectors     = 0;
        miscompares = 0;
        ev = 1'b0;
        es_a = 0; es_b = 0; eo_a = 1'b0; eo_b = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_out();
        chk("reset_sum_a", sum_a, 0);
        chk("reset_ready_a", ready_a, 1);
        rst = 1'b0;
        @(negedge clk);

        // Basic four-term group, result valid for exactly one cycle
        cycle(1, 64, 0, 1);
        cycle(1, -56, 0, 1);
        cycle(1, 15, 0, 1);
        cycle(1, -1, 0, 1);
        chk("dir_sum22", sum_a, 22);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Early termination, then a full group with a cleared counter
        cycle(1, 5, 0, 1);
        cycle(1, -3, 1, 1);
        chk("dir_sum2", sum_a, 2);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        chk("dir_sum4", sum_a, 4);

        // Backpressure with a pending beat taken on the transfer cycle
        cycle(1, 64, 0, 1);
        cycle(1, -56, 0, 1);
        cycle(1, 15, 0, 1);
        cycle(1, -1, 0, 0);
        repeat (3) cycle(1, 9, 0, 0);
        chk("bp_hold22", sum_a, 22);
        cycle(1, 9, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        chk("bp_sum12", sum_a, 12);
        cycle(0, 0, 0, 1);

        // Saturation in the narrow instance
        cycle(1, 64, 0, 1);
        cycle(1, 64, 0, 1);
        cycle(1, 64, 0, 1);
        cycle(1, -56, 0, 1);
        chk("sat_sum71", sum_b, 71);
        chk("sat_ovf1", ovf_b, 1);
        chk("wide_sum136", sum_a, 136);
        repeat (4) cycle(1, 1, 0, 1);
        chk("sat_ovf_clear", ovf_b, 0);

        // Full input range
        repeat (4) cycle(1, -128, 0, 1);
        chk("range_neg", sum_a, -512);
        repeat (4) cycle(1, 127, 0, 1);
        chk("range_pos", sum_a, 508);

        // Single-term groups back to back through HOLD
        repeat (5) cycle(1, $urandom_range(0, 255), 1, 1);

        // Reset mid-group, then a clean group
        cycle(1, 10, 0, 1);
        cycle(1, 20, 0, 1);
        async_reset();
        cycle(1, 1, 0, 1);
        cycle(1, 2, 0, 1);
        cycle(1, 3, 0, 1);
        cycle(1, 4, 0, 1);
        chk("post_rst_sum10", sum_a, 10);

        // Reset while holding a stalled result
        cycle(1, 7, 1, 0);
        cycle(0, 0, 0, 0);
        async_reset();
        cycle(0, 0, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                p = ($urandom_range(0, 1) == 0) ? -128 : 127;
            else
                p = int'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, p,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
